demux4_collect: RTL and testbench
=================================

// Module: demux4_collect
// PURPOSE
//   Receive end of the 4:1 bit-select interface: recovers a LANES-bit word from a
//   stream of (y, sel) samples, each carrying one bit and its lane index.
//   Accepted bits are written into lane sel; a completed word is presented with a
//   valid/ready handshake.
//   Sits downstream of mux4, which drives y = x[sel]; word out matches x in.
// PARAMETERS
//   LANES  4  number of lanes (word width); power of two, >= 2
//   SEL_W  2  select width = $clog2(LANES)
// PORTS
//   clk        in   1      rising-edge clock; sole clock of the block
//   rst        in   1      asynchronous, active-high reset
//   y          in   1      serial bit for lane sel
//   sel        in   SEL_W  lane index of y
//   in_valid   in   1      y/sel valid this cycle
//   in_ready   out  1      block can accept a sample this cycle
//   flush      in   1      synchronous discard of partially collected word
//   x          out  LANES  recovered word, bit i from sample with sel==i
//   out_valid  out  1      x holds a complete word
//   out_ready  in   1      consumer takes x this cycle
//   lane_mask  out  LANES  bit i = lane i filled in current word
//   dup_err    out  1      1-cycle pulse: accepted sample hit an already-filled lane
//   ovf_err    out  1      1-cycle pulse: in_valid asserted while in_ready=0
// BEHAVIOUR
//   Reset (async, rst=1): state=COLLECT, x=0, lane_mask=0, out_valid=0,
//     in_ready=1, dup_err=0, ovf_err=0.
//   States: COLLECT (in_ready=1, out_valid=0), HOLD (in_ready=0, out_valid=1).
//   COLLECT, accept = in_valid & in_ready:
//     x[sel]<=y, lane_mask[sel]<=1 at the clock edge.
//     If lane_mask[sel] was already 1: bit is overwritten, dup_err=1 next cycle.
//       Mask is unchanged.
//     If lane_mask | onehot(sel) == all-ones: go to HOLD.
//       out_valid=1 on the next cycle.
//   Latency: last-lane sample accepted in cycle N -> out_valid=1 in cycle N+1.
//   Sample order is free; any permutation of sel fills the word.
//   HOLD:
//     x and lane_mask are held stable while out_valid=1 & out_ready=0.
//     On out_ready=1: lane_mask<=0 and go to COLLECT.
//       in_ready=1 on the next cycle.
//     x keeps its old value until overwritten lane by lane.
//   in_valid while in_ready=0: sample dropped, ovf_err=1 next cycle.
//     This includes the cycle where out_ready=1 in HOLD: no same-cycle
//     bypass, so the sample is dropped.
//   flush=1:
//     Next state is COLLECT and lane_mask<=0; x is unchanged.
//     Takes priority over in_valid, which is ignored (no dup_err).
//     In HOLD, flush drops the completed word, as if it were consumed.
//   Error outputs are registered single-cycle pulses; never sticky.
//   Reset mid-word or mid-HOLD: immediate return to reset values; the partial
//     or held word is lost.
// TESTING
//   1. x=4'b1100 source; samples sel=0..3, y=0,0,1,1, in_valid each cycle.
//      -> out_valid=1 the cycle after sel=3 accepted, x=4'b1100,
//      lane_mask=4'hF.
//   2. Order sel=3,1,0,2 with y=1,0,1,1 -> x=4'b1101 after 4th sample;
//      dup_err stays 0.
//   3. sel=2 twice (y=0 then y=1) -> dup_err pulses 1 cycle after 2nd;
//      lane_mask=4'b0100 stays; bit2 of final x=1.
//   4. Word complete, out_ready=0 for 5 cycles with in_valid=1:
//      -> in_ready=0, x stable, ovf_err pulses each cycle.
//      Then out_ready=1 -> COLLECT next cycle, lane_mask=0.
//   5. Two samples accepted, then flush=1 with in_valid=1:
//      -> lane_mask=0, no dup_err.
//      Next 4 samples build a fresh word correctly.
//   6. rst asserted asynchronously mid-word and in HOLD:
//      -> outputs at reset values before the next clock edge;
//      a full word is collected correctly after release.

Source files
------------

// File: rtl/demux4_collect_if.sv
// demux4_collect_if: sample-in / word-out bundle for the 4:1 bit-select receiver.
//   y, sel, in_valid  -> sample stream (driven by master)
//   in_ready          <- receiver can take a sample
//   x, out_valid      <- recovered word and its valid
//   out_ready         -> consumer takes the word
// The slave modport is the receiver side; master is the source/consumer side.
interface demux4_collect_if #(
  parameter int unsigned LANES = 4,
  parameter int unsigned SEL_W = $clog2(LANES)
);
  logic             y;
  logic [SEL_W-1:0] sel;
  logic             in_valid;
  logic             in_ready;
  logic [LANES-1:0] x;
  logic             out_valid;
  logic             out_ready;

  modport slave (
    input  y, sel, in_valid, out_ready,
    output in_ready, x, out_valid
  );

  modport master (
    output y, sel, in_valid, out_ready,
    input  in_ready, x, out_valid
  );
endinterface

// File: rtl/demux4_collect.sv
// demux4_collect: rebuilds a LANES-bit word from (y, sel) samples, one bit per
// sample, and presents the completed word with a valid/ready handshake.
//   clk, rst   clock and asynchronous active-high reset
//   flush      synchronous discard of the partially collected (or held) word
//   bus        sample input and word output handshake (slave side)
//   lane_mask  lanes already filled in the current word
//   dup_err    1-cycle pulse: accepted sample landed on a filled lane
//   ovf_err    1-cycle pulse: sample offered while not ready (dropped)
module demux4_collect #(
  parameter int unsigned LANES = 4,
  parameter int unsigned SEL_W = $clog2(LANES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  demux4_collect_if.slave  bus,
  output logic [LANES-1:0] lane_mask,
  output logic             dup_err,
  output logic             ovf_err
);

  typedef enum logic [0:0] {StCollect, StHold} state_e;

  state_e           state_q, state_d;
  logic [LANES-1:0] x_q, x_d;
  logic [LANES-1:0] mask_q, mask_d;
  logic             dup_q, dup_d;
  logic             ovf_q, ovf_d;
  logic [SEL_W-1:0] sel;
  logic [LANES-1:0] sel_onehot;
  logic [LANES-1:0] mask_upd;

  assign sel        = bus.sel;
  assign sel_onehot = {{(LANES-1){1'b0}}, 1'b1} << sel;
  assign mask_upd   = mask_q | sel_onehot;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    mask_d  = mask_q;
    dup_d   = 1'b0;
    ovf_d   = 1'b0;
    if (flush) begin
      // Flush wins over any sample; in HOLD it drops the word as if consumed.
      state_d = StCollect;
      mask_d  = '0;
    end else begin
      case (state_q)
        StCollect: begin
          if (bus.in_valid) begin
            x_d[sel] = bus.y;
            mask_d   = mask_upd;
            dup_d    = mask_q[sel];
            if (mask_upd == {LANES{1'b1}}) state_d = StHold;
          end
        end
        StHold: begin
          // No same-cycle bypass: a sample here is dropped even when out_ready=1.
          ovf_d = bus.in_valid;
          if (bus.out_ready) begin
            mask_d  = '0;
            state_d = StCollect;
          end
        end
        default: state_d = StCollect;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StCollect;
      x_q     <= '0;
      mask_q  <= '0;
      dup_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      mask_q  <= mask_d;
      dup_q   <= dup_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == StCollect);
  assign bus.out_valid = (state_q == StHold);
  assign bus.x         = x_q;
  assign lane_mask     = mask_q;
  assign dup_err       = dup_q;
  assign ovf_err       = ovf_q;

endmodule

// File: tb/tb_demux4_collect.sv
// Directed bench for demux4_collect with hand-computed expected values.
module tb_demux4_collect;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic [3:0] lane_mask;
  logic       dup_err;
  logic       ovf_err;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  demux4_collect_if #(.LANES(4), .SEL_W(2)) bus ();

  demux4_collect #(.LANES(4), .SEL_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus),
    .lane_mask (lane_mask),
    .dup_err   (dup_err),
    .ovf_err   (ovf_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] s, input logic b);
    bus.sel      = s;
    bus.y        = b;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bus.y         = 1'b0;
    bus.sel       = 2'd0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    // Reset values
    #3;
    check("rst_x", bus.x, 4'h0);
    check("rst_mask", lane_mask, 4'h0);
    check("rst_ovalid", bus.out_valid, 1'b0);
    check("rst_iready", bus.in_ready, 1'b1);
    check("rst_dup", dup_err, 1'b0);
    check("rst_ovf", ovf_err, 1'b0);
    #4 rst = 1'b0;
    tick();

    // 1: in-order lanes, y=0,0,1,1 -> 4'b1100
    send(2'd0, 1'b0);
    send(2'd1, 1'b0);
    send(2'd2, 1'b1);
    check("t1_ovalid_early", bus.out_valid, 1'b0);
    check("t1_mask_partial", lane_mask, 4'h7);
    send(2'd3, 1'b1);
    check("t1_ovalid", bus.out_valid, 1'b1);
    check("t1_iready", bus.in_ready, 1'b0);
    check("t1_x", bus.x, 4'hC);
    check("t1_mask", lane_mask, 4'hF);
    consume();
    check("t1_cons_ovalid", bus.out_valid, 1'b0);
    check("t1_cons_iready", bus.in_ready, 1'b1);
    check("t1_cons_mask", lane_mask, 4'h0);
    check("t1_cons_xkeep", bus.x, 4'hC);

    // 2: order 3,1,0,2 with y=1,0,1,1 -> 4'b1101
    send(2'd3, 1'b1);
    check("t2_dup_a", dup_err, 1'b0);
    send(2'd1, 1'b0);
    check("t2_dup_b", dup_err, 1'b0);
    send(2'd0, 1'b1);
    check("t2_dup_c", dup_err, 1'b0);
    check("t2_mask", lane_mask, 4'hB);
    send(2'd2, 1'b1);
    check("t2_dup_d", dup_err, 1'b0);
    check("t2_ovalid", bus.out_valid, 1'b1);
    check("t2_x", bus.x, 4'hD);
    consume();

    // 3: lane 2 twice -> dup_err one-cycle pulse, mask unchanged, bit overwritten
    send(2'd2, 1'b0);
    check("t3_dup_first", dup_err, 1'b0);
    check("t3_mask_first", lane_mask, 4'h4);
    send(2'd2, 1'b1);
    check("t3_dup_pulse", dup_err, 1'b1);
    check("t3_mask_dup", lane_mask, 4'h4);
    tick();
    check("t3_dup_clear", dup_err, 1'b0);
    send(2'd0, 1'b1);
    send(2'd1, 1'b0);
    send(2'd3, 1'b0);
    check("t3_ovalid", bus.out_valid, 1'b1);
    check("t3_x", bus.x, 4'h5);

    // 4: held word, in_valid with out_ready=0 for 5 cycles -> ovf each cycle
    bus.sel      = 2'd1;
    bus.y        = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_ovf", ovf_err, 1'b1);
      check("t4_iready", bus.in_ready, 1'b0);
      check("t4_xstable", bus.x, 4'h5);
      check("t4_mask", lane_mask, 4'hF);
    end
    // Consume cycle with a sample offered: dropped, no bypass
    bus.sel       = 2'd0;
    bus.y         = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check("t4_cons_ovf", ovf_err, 1'b1);
    check("t4_cons_iready", bus.in_ready, 1'b1);
    check("t4_cons_mask", lane_mask, 4'h0);
    check("t4_cons_x", bus.x, 4'h5);
    tick();
    check("t4_ovf_clear", ovf_err, 1'b0);

    // 5: two samples, then flush with in_valid -> mask cleared, x kept, no dup
    send(2'd0, 1'b1);
    send(2'd1, 1'b1);
    check("t5_mask_pre", lane_mask, 4'h3);
    flush = 1'b1;
    send(2'd0, 1'b0);
    flush = 1'b0;
    check("t5_mask_flush", lane_mask, 4'h0);
    check("t5_dup_flush", dup_err, 1'b0);
    check("t5_x_flush", bus.x, 4'h7);
    send(2'd0, 1'b0);
    send(2'd1, 1'b1);
    send(2'd2, 1'b1);
    send(2'd3, 1'b0);
    check("t5_ovalid", bus.out_valid, 1'b1);
    check("t5_x", bus.x, 4'h6);
    check("t5_dup_none", dup_err, 1'b0);
    consume();

    // 6a: async reset mid-word
    send(2'd0, 1'b1);
    send(2'd1, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("t6a_mask", lane_mask, 4'h0);
    check("t6a_x", bus.x, 4'h0);
    check("t6a_iready", bus.in_ready, 1'b1);
    #2 rst = 1'b0;
    tick();

    // 6b: async reset while holding a word
    send(2'd0, 1'b1);
    send(2'd1, 1'b1);
    send(2'd2, 1'b1);
    send(2'd3, 1'b1);
    check("t6b_pre_ovalid", bus.out_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("t6b_ovalid", bus.out_valid, 1'b0);
    check("t6b_iready", bus.in_ready, 1'b1);
    check("t6b_x", bus.x, 4'h0);
    check("t6b_mask", lane_mask, 4'h0);
    #2 rst = 1'b0;
    tick();
    send(2'd0, 1'b1);
    send(2'd1, 1'b0);
    send(2'd2, 1'b1);
    send(2'd3, 1'b0);
    check("t6_after_ovalid", bus.out_valid, 1'b1);
    check("t6_after_x", bus.x, 4'h5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
